// File: rtl/shift_sub_divider.sv
// shift_sub_divider: restoring shift-subtract divider, one quotient bit per clock.
// Serves DIV/DIVU/REM/REMU with RISC-V divide-by-zero and signed-overflow results.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accept edge
//   CALC  | one shift-subtract step per cycle, W cycles in total
//   DONE  | result valid on the outputs until start drops
module shift_sub_divider #(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     move_flush,
    input  logic                     start,
    input  logic                     div_signed,
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic [OPERAND_WIDTH-1:0] quotient,
    output logic [OPERAND_WIDTH-1:0] remainder,
    output logic                     done
);

    localparam int W  = OPERAND_WIDTH;
    localparam int CW = $clog2(OPERAND_WIDTH);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(OPERAND_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_dvd;
    logic [W-1:0]    r_dvsr;
    // Partial remainder is always below the divisor after a step, so W bits hold it;
    // the extra bit only exists transiently in w_rem_sh.
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quot;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;

    logic [W-1:0]    w_abs_a;
    logic [W-1:0]    w_abs_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic [W:0]      w_rem_sh;
    logic [W-1:0]    w_sub;
    logic            w_ge;
    logic            w_last;

    // Magnitude of the most negative value stays 1<<(W-1) when read as unsigned.
    assign w_abs_a  = (div_signed && a[W-1]) ? (~a + 1'b1) : a;
    assign w_abs_b  = (div_signed && b[W-1]) ? (~b + 1'b1) : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = div_signed && (a == MIN_NEG) && (b == '1);

    assign w_rem_sh = {r_rem, r_dvd[W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
    // Low W bits of the difference are exact whenever w_ge holds.
    assign w_sub    = w_rem_sh[W-1:0] - r_dvsr;
    assign w_last   = (r_cnt == CNT_LAST);

    // State register; flush squashes any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (move_flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and done flag.
    always_comb begin
        w_next = r_state;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_b_zero || w_ovf) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, special-case results and the shift-subtract datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd   <= '0;
            r_dvsr  <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (move_flush) begin
            r_dvd   <= '0;
            r_dvsr  <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_dvd   <= '0;
                        r_dvsr  <= '0;
                        if (w_b_zero) begin
                            r_quot <= '1;
                            r_rem  <= a;
                        end else if (w_ovf) begin
                            r_quot <= a;
                            r_rem  <= '0;
                        end else begin
                            r_quot  <= '0;
                            r_rem   <= '0;
                            r_dvd   <= w_abs_a;
                            r_dvsr  <= w_abs_b;
                            r_neg_q <= div_signed && (a[W-1] ^ b[W-1]);
                            r_neg_r <= div_signed && a[W-1];
                        end
                    end
                end
                ST_CALC: begin
                    r_rem  <= w_ge ? w_sub : w_rem_sh[W-1:0];
                    r_dvd  <= {r_dvd[W-2:0], 1'b0};
                    r_quot <= {r_quot[W-2:0], w_ge};
                    r_cnt  <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    if (!start) begin
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign fixup from registered flags; negating zero yields zero.
    assign quotient  = (r_state == ST_DONE) ? (r_neg_q ? (~r_quot + 1'b1) : r_quot) : '0;
    assign remainder = (r_state == ST_DONE) ? (r_neg_r ? (~r_rem + 1'b1) : r_rem) : '0;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider: normal, signed, special-case, flush and reset vectors.
module tb_shift_sub_divider;

    logic        clk;
    logic        rst_n;
    logic        move_flush;
    logic        start;
    logic        div_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;

    int total;
    int bad;

    shift_sub_divider #(.OPERAND_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move_flush (move_flush),
        .start      (start),
        .div_signed (div_signed),
        .a          (a),
        .b          (b),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE, count edges to done (1 = right after E0),
    // check result, hold, then release start and check the return to zero.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int exp_lat);
        int n;
        n = 0;
        a = av;
        b = bv;
        div_signed = sgn;
        start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (i == 1) begin
                a = ~av;
                b = bv + 32'd3;
                div_signed = ~sgn;
            end
            if (done) break;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        repeat (2) @(posedge clk);
        #1;
        check({tag, " hold done"}, {31'd0, done}, 32'd1);
        check({tag, " hold quotient"}, quotient, exp_q);
        check({tag, " hold remainder"}, remainder, exp_r);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop done"}, {31'd0, done}, 32'd0);
        check({tag, " drop quotient"}, quotient, 32'd0);
        check({tag, " drop remainder"}, remainder, 32'd0);
    endtask

    initial begin
        int seen_done;
        int n;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        move_flush = 1'b0;
        start = 1'b0;
        div_signed = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_op("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
        run_op("s-6/3", 1'b1, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 32'd0, 33);
        run_op("s-8/-2", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 32'd0, 33);
        run_op("u div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
        run_op("s div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
        run_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1);
        run_op("u ovf-ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        // Flush 10 cycles into a calculation: done must never rise for it.
        a = 32'd1000;
        b = 32'd3;
        div_signed = 1'b0;
        start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        move_flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        move_flush = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("flush no done", 32'(seen_done), 32'd0);
        run_op("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);

        // Asynchronous reset in the middle of CALC.
        a = 32'd100;
        b = 32'd7;
        div_signed = 1'b0;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst calc done", {31'd0, done}, 32'd0);
        check("rst calc quotient", quotient, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op("u100/7 post-rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        // Asynchronous reset while a result is being held in DONE.
        a = 32'd20;
        b = 32'd3;
        div_signed = 1'b0;
        start = 1'b1;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (done) break;
        end
        check("rst-done latency", 32'(n), 32'd33);
        check("rst-done quotient", quotient, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst done done", {31'd0, done}, 32'd0);
        check("rst done quotient", quotient, 32'd0);
        check("rst done remainder", remainder, 32'd0);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
